pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage RISC-V pipeline. It watches the decode-stage source registers, the EX-stage load destination, EX-stage branch resolution and the data-memory handshake. It drives write-enable and flush controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It also keeps saturating stall and flush performance counters and provides a sticky halt / memory-timeout status.

## Interface
- MEM_TIMEOUT, 16: maximum consecutive memory-wait cycles before a timeout fault; legal range 2..65535.
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_rs1, id_rs2  in  5 each  source register indices of the instruction in ID.
- id_uses_rs1, id_uses_rs2  in  1 each  ID instruction actually reads that source.
- ex_rd  in  5  destination index of the instruction in EX.
- ex_mem_read  in  1  EX instruction is a load.
- ex_branch_taken  in  1  branch/jump resolved taken in EX this cycle.
- mem_req  in  1  MEM stage has an active data-memory access.
- mem_ready  in  1  data memory completes the access this cycle.
- halt_req  in  1  ecall/ebreak reached MEM; request pipeline halt.
- pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write  out  1 each  register load enables.
- if_id_flush, id_ex_flush  out  1 each  the register loads a NOP bubble at the next edge; flush overrides write.
- halted  out  1  pipeline is frozen in HALT.
- mem_error  out  1  sticky memory-timeout fault.
- stall_cycles  out  16  saturating count of cycles with pc_write=0 outside HALT.
- flush_count  out  16  saturating count of taken-branch flushes.

## Operation
- States: RUN, WAIT, HALT. Control outputs are combinational (Mealy) from state and the current inputs. State, counters and status are registered.
- load_use = ex_mem_read && ex_rd!=0 && ((id_uses_rs1 && ex_rd==id_rs1) || (id_uses_rs2 && ex_rd==id_rs2)).
- mem_stall = mem_req && !mem_ready.
- Priority is evaluated each cycle in RUN, and in WAIT once mem_ready=1:
  1. halt_req
  2. mem_stall
  3. ex_branch_taken
  4. load_use
  5. normal
- halt_req: all writes 0, no flush; next state HALT.
- mem_stall: all five writes 0, no flush; next state WAIT; wait_cnt<=1.
- ex_branch_taken: all writes 1, if_id_flush=1, id_ex_flush=1; flush_count++. A load_use in the same cycle is ignored because its instruction is wrong-path.
- load_use: pc_write=0, if_id_write=0, id_ex_flush=1, ex_mem_write=1, mem_wb_write=1; stall_cycles++.
- normal: all writes 1, no flush.
- WAIT with mem_ready=0:
  - Outputs are frozen as for mem_stall, and wait_cnt++.
  - If wait_cnt==MEM_TIMEOUT-1 at the edge, next state is HALT and mem_error<=1.
- WAIT with mem_ready=1: outputs follow the priority list, excluding the mem_stall entry. Next state is RUN, or HALT if halt_req.
- HALT: all writes 0, no flush, halted=1. HALT exits only via reset.
- stall_cycles increments on every cycle in RUN/WAIT with pc_write=0, saturating at 0xFFFF. flush_count saturates at 0xFFFF.
- Reset (rst_n=0, asynchronous):
  - state=RUN, wait_cnt=0, stall_cycles=0, flush_count=0, mem_error=0, halted=0.
  - While rst_n=0: all writes 0, if_id_flush=1, id_ex_flush=1.
  - Reset asserted mid-WAIT aborts the wait with no mem_error.

## Timing
- Zero-cycle control latency: outputs respond combinationally to inputs in the same cycle and take effect at the next rising clk.
- A load-use hazard costs exactly one bubble. At the next edge EX holds the bubble, so load_use deasserts.
- A taken branch costs two squashed instructions (IF/ID and ID/EX) and no extra stall.
- A memory wait of N cycles with mem_ready=0 gives N frozen cycles. mem_ready=1 in the first cycle gives no WAIT entry.
- The timeout fires at the edge ending the MEM_TIMEOUT-th consecutive frozen cycle. halted=1 and mem_error=1 are visible after that edge.
- State, counters and status update only on the rising clk, except for asynchronous reset.

## Test plan
- **Load-use stall:** ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 for one cycle.
  - Required: pc_write=0, if_id_write=0, id_ex_flush=1.
  - Required: stall_cycles 0 -> 1.
  - Repeat with ex_rd=0 and with id_uses_rs2=0: no stall.
- **Branch beats load-use:** ex_branch_taken=1 together with a load_use match.
  - Required: if_id_flush=id_ex_flush=1, pc_write=1.
  - Required: flush_count=1, stall_cycles=0.
- **Memory wait:** mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1.
  - Required: 3 cycles with all writes 0, then all writes 1.
  - Required: stall_cycles=3, state back to RUN.
- **Memory timeout:** MEM_TIMEOUT=4, mem_req=1, mem_ready held 0.
  - Required: after the 4th frozen cycle, mem_error=1 and halted=1.
  - Required: writes stay 0 indefinitely, even after mem_ready=1.
  - Required: rst_n pulse clears everything.
- **Halt priority:** halt_req=1 with mem_stall=1 and ex_branch_taken=1 in RUN.
  - Required: no flush, flush_count unchanged, halted=1 next cycle.
- **Saturation and reset:** preload 0xFFFE stall cycles via back-to-back waits, then 3 more stalled cycles.
  - Required: stall_cycles holds 0xFFFF.
  - Assert rst_n=0 asynchronously mid-WAIT: counters=0 immediately, outputs show flushes=1 and writes=0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Central stall/flush sequencer for the 5-stage RISC-V pipeline.
//   It resolves the following hazards by fixed priority each cycle:
//     halt request > memory wait > taken branch > load-use
//   From that decision it drives the register load enables and the bubble
//   (flush) controls. It also keeps saturating stall/flush performance
//   counters and a sticky halt / memory-timeout status.
//
// Parameters
//   MEM_TIMEOUT   consecutive memory-wait cycles before a timeout fault (2..65535)
//
// Ports
//   clk, rst_n                 pipeline clock (rising edge), async active-low reset
//   id_rs1, id_rs2             ID-stage source register indices
//   id_uses_rs1, id_uses_rs2   ID instruction really reads that source
//   ex_rd, ex_mem_read         EX-stage destination index / EX instruction is a load
//   ex_branch_taken            branch/jump resolved taken in EX this cycle
//   mem_req, mem_ready         data-memory access active / completing this cycle
//   halt_req                   ecall/ebreak reached MEM
//   pc_write .. mem_wb_write   pipeline register load enables
//   if_id_flush, id_ex_flush   load a NOP bubble at the next edge (overrides write)
//   halted, mem_error          frozen in HALT / sticky memory-timeout fault
//   stall_cycles, flush_count  saturating performance counters
module pipeline_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        ex_branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  input  logic        halt_req,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        id_ex_write,
  output logic        ex_mem_write,
  output logic        mem_wb_write,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        halted,
  output logic        mem_error,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_count
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    HALT = 2'd2
  } state_t;

  // Per-cycle decision. FROZEN covers both a WAIT cycle still waiting on
  // memory and the HALT state.
  typedef enum logic [2:0] {
    ACT_NORMAL    = 3'd0,
    ACT_LOAD_USE  = 3'd1,
    ACT_BRANCH    = 3'd2,
    ACT_MEM_STALL = 3'd3,
    ACT_HALT      = 3'd4,
    ACT_FROZEN    = 3'd5
  } action_t;

  // wait_cnt already counts the cycle that entered WAIT, so the timeout
  // fires when it reaches MEM_TIMEOUT-1 in a still-waiting WAIT cycle.
  localparam logic [15:0] WAIT_LIMIT = 16'(MEM_TIMEOUT - 1);
  localparam logic [15:0] CNT_MAX    = 16'hFFFF;

  state_t      state;
  action_t     action;
  logic [15:0] wait_cnt;
  logic        load_use;
  logic        mem_stall;

  assign load_use  = ex_mem_read && (ex_rd != 5'd0) &&
                     ((id_uses_rs1 && (ex_rd == id_rs1)) ||
                      (id_uses_rs2 && (ex_rd == id_rs2)));
  assign mem_stall = mem_req && !mem_ready;

  // Priority resolution. Once memory completes in WAIT, the mem_stall entry
  // cannot apply (mem_ready is high), so the remaining order is the same as in RUN.
  always_comb begin
    action = ACT_FROZEN;
    case (state)
      RUN: begin
        if (halt_req)             action = ACT_HALT;
        else if (mem_stall)       action = ACT_MEM_STALL;
        else if (ex_branch_taken) action = ACT_BRANCH;
        else if (load_use)        action = ACT_LOAD_USE;
        else                      action = ACT_NORMAL;
      end
      WAIT: begin
        if (!mem_ready)           action = ACT_FROZEN;
        else if (halt_req)        action = ACT_HALT;
        else if (ex_branch_taken) action = ACT_BRANCH;
        else if (load_use)        action = ACT_LOAD_USE;
        else                      action = ACT_NORMAL;
      end
      default:                    action = ACT_FROZEN;
    endcase
  end

  // Mealy control outputs. While in reset every stage is held and the two
  // front registers are bubbled, so the pipeline restarts clean.
  always_comb begin
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    id_ex_write  = 1'b0;
    ex_mem_write = 1'b0;
    mem_wb_write = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    if (!rst_n) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else begin
      case (action)
        ACT_NORMAL: begin
          pc_write     = 1'b1;
          if_id_write  = 1'b1;
          id_ex_write  = 1'b1;
          ex_mem_write = 1'b1;
          mem_wb_write = 1'b1;
        end
        ACT_BRANCH: begin
          pc_write     = 1'b1;
          if_id_write  = 1'b1;
          id_ex_write  = 1'b1;
          ex_mem_write = 1'b1;
          mem_wb_write = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
        end
        // Hold PC and IF/ID, push a bubble into EX, let older stages drain.
        ACT_LOAD_USE: begin
          id_ex_write  = 1'b1;
          ex_mem_write = 1'b1;
          mem_wb_write = 1'b1;
          id_ex_flush  = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Sequencer state, wait timer, sticky status and performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      wait_cnt     <= 16'd0;
      halted       <= 1'b0;
      mem_error    <= 1'b0;
      stall_cycles <= 16'd0;
      flush_count  <= 16'd0;
    end else begin
      case (state)
        RUN: begin
          if (action == ACT_HALT) begin
            state  <= HALT;
            halted <= 1'b1;
          end else if (action == ACT_MEM_STALL) begin
            state    <= WAIT;
            wait_cnt <= 16'd1;
          end
        end
        WAIT: begin
          if (!mem_ready) begin
            if (wait_cnt == WAIT_LIMIT) begin
              state     <= HALT;
              halted    <= 1'b1;
              mem_error <= 1'b1;
              wait_cnt  <= 16'd0;
            end else begin
              wait_cnt <= wait_cnt + 16'd1;
            end
          end else begin
            wait_cnt <= 16'd0;
            if (action == ACT_HALT) begin
              state  <= HALT;
              halted <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        HALT: begin
        end
        default: begin
          state  <= HALT;
          halted <= 1'b1;
        end
      endcase

      if ((state != HALT) && !pc_write && (stall_cycles != CNT_MAX))
        stall_cycles <= stall_cycles + 16'd1;

      if ((action == ACT_BRANCH) && (flush_count != CNT_MAX))
        flush_count <= flush_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl
//   Directed self-checking bench for pipeline_hazard_ctrl, built with
//   MEM_TIMEOUT=4 so the timeout path is reachable in a few cycles.
//   The control outputs are compared as one packed vector:
//   {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
//    if_id_flush, id_ex_flush}
module tb_pipeline_hazard_ctrl;

  localparam logic [6:0] C_NORMAL   = 7'b11111_00;
  localparam logic [6:0] C_FROZEN   = 7'b00000_00;
  localparam logic [6:0] C_RESET    = 7'b00000_11;
  localparam logic [6:0] C_LOADUSE  = 7'b00111_01;
  localparam logic [6:0] C_BRANCH   = 7'b11111_11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_uses_rs1, id_uses_rs2;
  logic        ex_mem_read, ex_branch_taken, mem_req, mem_ready, halt_req;
  logic        pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
  logic        if_id_flush, id_ex_flush, halted, mem_error;
  logic [15:0] stall_cycles, flush_count;
  logic [6:0]  ctrl;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign ctrl = {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
                 if_id_flush, id_ex_flush};

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .halt_req(halt_req),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
    .ex_mem_write(ex_mem_write), .mem_wb_write(mem_wb_write),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .halted(halted), .mem_error(mem_error),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  task automatic checkOutput(input string tag, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2,
                               input logic [4:0] rd, input logic mread,
                               input logic br, input logic mreq,
                               input logic mrdy, input logic hreq);
    id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
    ex_rd = rd; ex_mem_read = mread; ex_branch_taken = br;
    mem_req = mreq; mem_ready = mrdy; halt_req = hreq;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Mid-cycle reset pulse that also checks the cleared state.
  task automatic pulseReset(input string tag);
    rst_n = 1'b0;
    #1;
    checkOutput({tag, "_stall"}, stall_cycles, 16'h0000);
    checkOutput({tag, "_flush"}, flush_count, 16'h0000);
    checkOutput({tag, "_halted"}, {15'd0, halted}, 16'd0);
    checkOutput({tag, "_memerr"}, {15'd0, mem_error}, 16'd0);
    checkOutput({tag, "_ctrl"}, {9'd0, ctrl}, {9'd0, C_RESET});
    rst_n = 1'b1;
    #1;
  endtask

  // One cycle of the back-to-back wait pattern; every cycle stalls the PC.
  task automatic satPhase(input int i);
    case (i % 4)
      3:       applyStimulus(5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      default: applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endcase
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_ctrl", {9'd0, ctrl}, {9'd0, C_RESET});
    checkOutput("rst_stall", stall_cycles, 16'h0000);
    checkOutput("rst_flush", flush_count, 16'h0000);
    checkOutput("rst_halted", {15'd0, halted}, 16'd0);
    checkOutput("rst_memerr", {15'd0, mem_error}, 16'd0);
    #10 rst_n = 1'b1;
    tick();

    // Normal flow
    applyStimulus(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("normal_ctrl", {9'd0, ctrl}, {9'd0, C_NORMAL});
    tick();

    // Load-use on rs2
    applyStimulus(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_ctrl", {9'd0, ctrl}, {9'd0, C_LOADUSE});
    tick();
    checkOutput("lu_stall", stall_cycles, 16'd1);

    // ex_rd = x0 never hazards
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_x0_ctrl", {9'd0, ctrl}, {9'd0, C_NORMAL});
    tick();
    // Matching index but rs2 unused
    applyStimulus(5'd0, 5'd5, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_unused_ctrl", {9'd0, ctrl}, {9'd0, C_NORMAL});
    tick();
    checkOutput("lu_nostall", stall_cycles, 16'd1);

    // Load-use on rs1
    applyStimulus(5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_rs1_ctrl", {9'd0, ctrl}, {9'd0, C_LOADUSE});
    tick();
    checkOutput("lu_rs1_stall", stall_cycles, 16'd2);

    // Branch beats load-use
    applyStimulus(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("br_ctrl", {9'd0, ctrl}, {9'd0, C_BRANCH});
    tick();
    checkOutput("br_flushcnt", flush_count, 16'd1);
    checkOutput("br_stall", stall_cycles, 16'd2);

    // Memory wait: three frozen cycles then completion
    for (int i = 0; i < 3; i++) begin
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("memwait_ctrl%0d", i), {9'd0, ctrl}, {9'd0, C_FROZEN});
      tick();
    end
    checkOutput("memwait_stall", stall_cycles, 16'd5);
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("memdone_ctrl", {9'd0, ctrl}, {9'd0, C_NORMAL});
    tick();
    checkOutput("memdone_stall", stall_cycles, 16'd5);

    // Halt priority; also proves the FSM went back to RUN (WAIT would ignore halt_req)
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("halt_ctrl", {9'd0, ctrl}, {9'd0, C_FROZEN});
    tick();
    checkOutput("halt_halted", {15'd0, halted}, 16'd1);
    checkOutput("halt_flushcnt", flush_count, 16'd1);
    checkOutput("halt_memerr", {15'd0, mem_error}, 16'd0);
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("halt_hold_ctrl", {9'd0, ctrl}, {9'd0, C_FROZEN});
    pulseReset("halt_rst");
    tick();

    // Memory timeout with MEM_TIMEOUT=4
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    checkOutput("to_pre_halted", {15'd0, halted}, 16'd0);
    checkOutput("to_pre_memerr", {15'd0, mem_error}, 16'd0);
    checkOutput("to_pre_ctrl", {9'd0, ctrl}, {9'd0, C_FROZEN});
    tick();
    checkOutput("to_halted", {15'd0, halted}, 16'd1);
    checkOutput("to_memerr", {15'd0, mem_error}, 16'd1);
    checkOutput("to_stall", stall_cycles, 16'd4);
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("to_ready_ctrl", {9'd0, ctrl}, {9'd0, C_FROZEN});
    tick();
    tick();
    checkOutput("to_hold_ctrl", {9'd0, ctrl}, {9'd0, C_FROZEN});
    checkOutput("to_hold_stall", stall_cycles, 16'd4);
    checkOutput("to_hold_memerr", {15'd0, mem_error}, 16'd1);
    pulseReset("to_rst");
    tick();

    // Saturation: 0xFFFE stalled cycles of back-to-back waits
    for (int i = 0; i < 65534; i++) satPhase(i);
    checkOutput("sat_preload", stall_cycles, 16'hFFFE);
    checkOutput("sat_no_timeout", {15'd0, halted}, 16'd0);
    for (int i = 65534; i < 65537; i++) satPhase(i);
    checkOutput("sat_hold", stall_cycles, 16'hFFFF);

    // Now in WAIT: asynchronous reset mid-cycle aborts without mem_error
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("wait_ctrl", {9'd0, ctrl}, {9'd0, C_FROZEN});
    #1 rst_n = 1'b0;
    #1;
    checkOutput("arst_stall", stall_cycles, 16'h0000);
    checkOutput("arst_ctrl", {9'd0, ctrl}, {9'd0, C_RESET});
    checkOutput("arst_memerr", {15'd0, mem_error}, 16'd0);
    tick();
    rst_n = 1'b1;
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("post_rst_ctrl", {9'd0, ctrl}, {9'd0, C_NORMAL});
    tick();
    checkOutput("post_rst_halted", {15'd0, halted}, 16'd0);
    checkOutput("post_rst_stall", stall_cycles, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
